// File: rtl/crypto_round_ctrl.sv
// Eleven-round 8-bit keyed permutation controller: encrypt runs rounds 0..10, decrypt runs 10..0.
// Optional abort input is enabled by defining CRYPTO_ROUND_CTRL_ABORT_EN.
module crypto_round_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] in_key,
    input  logic [7:0] din,
`ifdef CRYPTO_ROUND_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic [3:0] round_idx
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t     r_state;
    logic [7:0] r_s;
    logic [7:0] r_key;
    logic       r_mode;
    logic [3:0] r_idx;
    logic [7:0] r_dout;
    logic       r_busy;
    logic       r_done;

    logic [7:0] w_rk;
    logic [7:0] w_x;
    logic [7:0] w_enc;
    logic [7:0] w_dec;
    logic [7:0] w_next;
    logic       w_last;
    logic       w_abort;

`ifdef CRYPTO_ROUND_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_rk = r_key;
        case (r_idx)
            4'd0:    w_rk = r_key;
            4'd1:    w_rk = {r_key[6:0], r_key[7]};
            4'd2:    w_rk = r_key ^ 8'hAA;
            4'd3:    w_rk = {r_key[0], r_key[7:1]};
            4'd4:    w_rk = ~r_key;
            4'd5:    w_rk = r_key + 8'h1F;
            4'd6:    w_rk = r_key - 8'h1F;
            4'd7:    w_rk = {r_key[3:0], r_key[7:4]};
            4'd8:    w_rk = r_key ^ 8'h55;
            4'd9:    w_rk = {r_key[5:0], r_key[7:6]};
            4'd10:   w_rk = {r_key[6:0], r_key[7]};
            default: w_rk = r_key;
        endcase
    end

    always_comb begin
        w_x    = r_s ^ w_rk;
        w_enc  = {w_x[6:0], w_x[7]};
        w_dec  = {r_s[0], r_s[7:1]} ^ w_rk;
        w_next = r_mode ? w_dec : w_enc;
        // Decrypt walks the key schedule backwards, so its final round is index 0.
        w_last = r_mode ? (r_idx == 4'd0) : (r_idx == 4'd10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_s     <= 8'h00;
            r_key   <= 8'h00;
            r_mode  <= 1'b0;
            r_idx   <= 4'd0;
            r_dout  <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_s     <= din;
                        r_key   <= in_key;
                        r_mode  <= mode;
                        r_idx   <= mode ? 4'd10 : 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_idx   <= 4'd0;
                    end else begin
                        r_s <= w_next;
                        if (w_last) begin
                            r_state <= StDone;
                            r_dout  <= w_next;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_idx   <= 4'd0;
                        end else if (r_mode) begin
                            r_idx <= r_idx - 4'd1;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_idx   <= 4'd0;
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign busy      = r_busy;
    assign done      = r_done;
    assign round_idx = r_idx;

endmodule

// File: tb/tb_crypto_round_ctrl.sv
// Randomized self-checking bench for crypto_round_ctrl against an arithmetic reference model.
// Define CRYPTO_ROUND_CTRL_ABORT_EN to also exercise the abort path.
module tb_crypto_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] in_key;
    logic [7:0] din;
    logic       abort;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic [3:0] round_idx;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] exp_dout;
    logic [7:0] ct;

    always #5 clk = ~clk;

    crypto_round_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_key    (in_key),
        .din       (din),
`ifdef CRYPTO_ROUND_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .dout      (dout),
        .busy      (busy),
        .done      (done),
        .round_idx (round_idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rol(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    function automatic int rk(input int k, input int r);
        case (r)
            0:       return k;
            1:       return rol(k, 1);
            2:       return k ^ 'hAA;
            3:       return rol(k, 7);
            4:       return 255 - k;
            5:       return (k + 31) % 256;
            6:       return (k + 256 - 31) % 256;
            7:       return (k % 16) * 16 + k / 16;
            8:       return k ^ 'h55;
            9:       return rol(k, 2);
            default: return rol(k, 1);
        endcase
    endfunction

    function automatic logic [7:0] model(input logic m, input logic [7:0] k, input logic [7:0] d);
        int s = int'(d);
        if (!m) begin
            for (int r = 0; r <= 10; r++) s = rol(s ^ rk(int'(k), r), 1);
        end else begin
            for (int r = 10; r >= 0; r--) s = rol(s, 7) ^ rk(int'(k), r);
        end
        return s[7:0];
    endfunction

    // Entered just after a rising edge with the DUT idle; leaves just after the edge following DONE.
    task automatic run_op(input logic m, input logic [7:0] k, input logic [7:0] d,
                          input bit poke, input bit with_abort);
        logic [7:0] res;
        res    = model(m, k, d);
        start  = 1'b1;
        mode   = m;
        in_key = k;
        din    = d;
        abort  = with_abort;
        @(posedge clk); #1;
        start  = 1'b0;
        abort  = 1'b0;
        mode   = 1'($urandom);
        in_key = 8'($urandom);
        din    = 8'($urandom);
        for (int c = 1; c <= 11; c++) begin
            if (poke && c == 4) start = 1'b1;
            @(negedge clk);
            check_eq("busy_run", busy, 1);
            check_eq("done_run", done, 0);
            check_eq("round_idx", round_idx, m ? 11 - c : c - 1);
            check_eq("dout_hold", dout, exp_dout);
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (poke) start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        check_eq("done_pulse", done, 1);
        check_eq("busy_done", busy, 0);
        check_eq("idx_done", round_idx, 0);
        check_eq("dout_result", dout, res);
        exp_dout = res;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check_eq("done_once", done, 0);
        check_eq("idle_after", busy, 0);
        check_eq("dout_after", dout, exp_dout);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        mode     = 1'b0;
        in_key   = 8'h12;
        din      = 8'h34;
        abort    = 1'b0;
        exp_dout = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_idx", round_idx, 0);
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check_eq("vec_enc_fb", dout, 8'hFB);
        run_op(1'b1, 8'h00, 8'hFB, 1'b1, 1'b0);
        check_eq("vec_dec_00", dout, 8'h00);
        run_op(1'b0, 8'hA7, 8'h3C, 1'b0, 1'b0);
        ct = dout;
        run_op(1'b1, 8'hA7, ct, 1'b0, 1'b0);
        check_eq("round_trip", dout, 8'h3C);

        // Reset in the middle of round 5.
        start  = 1'b1;
        mode   = 1'b0;
        in_key = 8'($urandom);
        din    = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("pre_rst_idx", round_idx, 5);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_dout", dout, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_idx", round_idx, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        exp_dout = 8'h00;
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        @(posedge clk); #1;
        run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);

`ifdef CRYPTO_ROUND_CTRL_ABORT_EN
        start  = 1'b1;
        mode   = 1'b0;
        in_key = 8'($urandom);
        din    = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(negedge clk);
        check_eq("abort_idx", round_idx, 3);
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_idx0", round_idx, 0);
        check_eq("abort_dout", dout, exp_dout);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
`endif

        for (int i = 0; i < 20; i++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/crypto_round_ctrl.md
CRYPTO_ROUND_CTRL -- requirements
Module: crypto_round_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1 bit, request to begin one 11-round operation.
REQ-004 SHALL have port mode, input, 1 bit, 0 = encrypt, 1 = decrypt; sampled with start.
REQ-005 SHALL have port in_key, input, 8 bits, base key; sampled with start.
REQ-006 SHALL have port din, input, 8 bits, plaintext or ciphertext; sampled with start.
REQ-007 SHALL have port dout, output, 8 bits, result register.
REQ-008 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-010 SHALL have port round_idx, output, 4 bits, index of the round key applied this cycle; 0 when idle.
REQ-011 SHALL have port abort, input, 1 bit; present only when ABORT_EN is defined (see Configuration).

Function
REQ-012 SHALL implement states IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 SHALL latch din, in_key and mode, set busy, and move to RUN.
REQ-014 Round key rk[r] SHALL be derived from the latched key K as follows.
- rk0=K, rk1=rol1(K), rk2=K^AA, rk3=ror1(K).
- rk4=~K, rk5=K+1F mod 256, rk6=K-1F mod 256, rk7=nibble swap.
- rk8=K^55, rk9=rol2(K), rk10=rol1(K).
REQ-015 Encrypt: the block SHALL process one round per cycle for r=0..10 in order, with s <= rol1(s ^ rk[r]).
REQ-016 Decrypt: the block SHALL process one round per cycle for r=10..0 in order, with s <= ror1(s) ^ rk[r]; decrypt SHALL exactly invert encrypt for the same key.
REQ-017 RUN SHALL last exactly 11 cycles.
REQ-018 After the final round, the block SHALL enter DONE for one cycle, loading dout with s, pulsing done=1 and clearing busy.
REQ-019 From DONE, the block SHALL return to IDLE; total latency from start-accept edge to done is 12 cycles.
REQ-020 start SHALL be ignored while busy=1 or in DONE.
REQ-021 start in IDLE on the cycle after DONE SHALL be accepted, so operations can run back to back.
REQ-022 dout SHALL hold its value until the next DONE and SHALL NOT change during RUN.
REQ-023 All arithmetic SHALL be 8-bit modulo 256.
REQ-024 round_idx SHALL equal r during RUN and 0 in IDLE and DONE.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, dout=00, busy=0, done=0, round_idx=0, and clear the internal state and latched registers to 0, including mid-operation.
REQ-026 A start coincident with rst=1 SHALL be ignored; the first accepted start is on the first rising edge with rst=0.

Configuration
REQ-027 The block SHALL support the macro CRYPTO_ROUND_CTRL_ABORT_EN.
- Defined: the abort port exists. abort=1 during RUN returns the block to IDLE on the next edge with busy=0, no done pulse, and dout unchanged.
- Defined, abort=1 in IDLE or DONE: no effect.
- Defined, abort and start both high in IDLE: start takes effect.
- Not defined: no abort port; every accepted operation runs to completion.

Verification
REQ-028 Encrypt with din=00, key=00: after 12 cycles, done pulses once and dout=FB.
REQ-029 Decrypt with din=FB, key=00: dout=00. Round trip with din=3C, key=A7: decrypt(encrypt(din))=3C.
REQ-030 Pulse start during RUN: the pulse is ignored and round_idx continues incrementing 0..10 without restart. Back-to-back start on the cycle after done is accepted.
REQ-031 Assert rst at round 5, then release: all outputs read 0 and the block is IDLE; a new start runs a full 12-cycle operation.
REQ-032 With CRYPTO_ROUND_CTRL_ABORT_EN defined, assert abort at round 3: busy=0 on the next cycle, no done pulse, and dout retains its previous value.
